// File: rtl/icache_pkg.sv
// icache_pkg: shared types and sizing helpers for the set-associative
// instruction cache (icache_sa) and its per-way storage (icache_way).
//   icache_state_t : controller states IDLE / REFILL / GAP / RESPOND
//   off_bits       : word-offset field width from LINE_WORDS
//   idx_bits       : set-index field width from NUM_SETS
//   tag_bits       : tag width left over from a 32-bit byte address
//   nz_width       : turns a zero field width into a 1-bit vector width
package icache_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFILL  = 2'd1,
    GAP     = 2'd2,
    RESPOND = 2'd3
  } icache_state_t;

  function automatic int unsigned off_bits(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned num_sets,
                                           input int unsigned line_words);
    return 32 - $clog2(WORD_BYTES) - $clog2(num_sets) - $clog2(line_words);
  endfunction

  // One-word lines (or one-way caches) have no field, but still need a
  // legal vector width for the signals that would carry it.
  function automatic int unsigned nz_width(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/icache_way.sv
// icache_way: storage for one way of icache_sa.
//   Holds per-set valid bits (async active-low reset), per-set tags and
//   per-set line data (tags/data are not reset).
//   Read side (combinational): i_rd_idx/i_rd_off/i_rd_tag -> o_valid
//     (valid bit of the indexed set), o_hit (valid and tag match),
//     o_word (data word at idx/off, regardless of hit).
//   Write side (registered): i_wr_en writes i_wr_data at i_wr_idx/i_wr_off;
//     i_inst_en writes i_inst_tag and sets the valid bit at i_wr_idx.
module icache_way
  import icache_pkg::*;
#(
  parameter int unsigned NUM_SETS   = 8,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned IDX_W      = 3,
  parameter int unsigned OFF_W      = 2,
  parameter int unsigned TAG_W      = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic [OFF_W-1:0] i_rd_off,
  input  logic [TAG_W-1:0] i_rd_tag,
  output logic             o_valid,
  output logic             o_hit,
  output logic [31:0]      o_word,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [OFF_W-1:0] i_wr_off,
  input  logic [31:0]      i_wr_data,
  input  logic             i_inst_en,
  input  logic [TAG_W-1:0] i_inst_tag
);

  localparam int unsigned DEPTH = NUM_SETS * LINE_WORDS;
  localparam int unsigned AW    = nz_width($clog2(DEPTH));

  logic [31:0]         r_data [DEPTH];
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  logic [NUM_SETS-1:0] r_valid;

  logic [AW-1:0] w_rd_addr;
  logic [AW-1:0] w_wr_addr;

  // Flat word address = set * LINE_WORDS + offset.
  assign w_rd_addr = AW'(i_rd_idx) * AW'(LINE_WORDS) + AW'(i_rd_off);
  assign w_wr_addr = AW'(i_wr_idx) * AW'(LINE_WORDS) + AW'(i_wr_off);

  assign o_valid = r_valid[i_rd_idx];
  assign o_hit   = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
  assign o_word  = r_data[w_rd_addr];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data[w_wr_addr] <= i_wr_data;
    end
    if (i_inst_en) begin
      r_tag[i_wr_idx] <= i_inst_tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
    end else if (i_inst_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/icache_sa.sv
// icache_sa: set-associative instruction cache with multi-word lines and
// per-set round-robin replacement.
//   Fetch side : A (byte address), RE (request), RD (word), RDY (1-cycle pulse)
//   Memory side: MAddr (word-aligned byte address), MRead, MData, MRdy
//   Optional   : hit_count / miss_count, present when ICACHE_PERF_EN is defined
//   clk rising edge; reset is asynchronous, active-low.
// A miss refills the whole line one word per handshake, with one MRead-low
// GAP cycle between words, then RESPOND installs tag/valid and answers.
module icache_sa
  import icache_pkg::*;
#(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned NUM_SETS   = 8,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  output logic [31:0] RD,
  input  logic        RE,
  output logic        RDY,
  output logic [31:0] MAddr,
  input  logic [31:0] MData,
  output logic        MRead,
  input  logic        MRdy
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned OFF       = off_bits(LINE_WORDS);
  localparam int unsigned OFF_W     = nz_width(OFF);
  localparam int unsigned IDX_W     = idx_bits(NUM_SETS);
  localparam int unsigned TAG_W     = tag_bits(NUM_SETS, LINE_WORDS);
  localparam int unsigned VW        = nz_width($clog2(WAYS));
  localparam int unsigned IDX_SH    = $clog2(WORD_BYTES) + OFF;
  localparam int unsigned TAG_SH    = IDX_SH + IDX_W;
  localparam logic [31:0] LINE_MASK = ~((32'(LINE_WORDS) * 32'(WORD_BYTES)) - 32'd1);
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  icache_state_t r_state, w_state_nx;

  logic [31:0]      r_rd, w_rd_nx;
  logic             r_rdy, w_rdy_nx;
  logic [31:0]      r_maddr, w_maddr_nx;
  logic             r_mread, w_mread_nx;
  logic [31:0]      r_addr, w_addr_nx;
  logic [OFF_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
  logic [VW-1:0]    r_victim, w_victim_nx;
  logic             r_vic_ptr, w_vic_ptr_nx;
  logic [VW-1:0]    r_ptr [NUM_SETS];

  logic             w_refill_wr;
  logic             w_install;

  // Address fields of the live request and of the latched miss address.
  logic [OFF_W-1:0] w_a_off, w_l_off, w_lk_off;
  logic [IDX_W-1:0] w_a_idx, w_l_idx, w_lk_idx;
  logic [TAG_W-1:0] w_a_tag, w_l_tag;
  logic [31:0]      w_base;

  assign w_a_off = OFF_W'((A >> $clog2(WORD_BYTES)) & 32'(LINE_WORDS - 1));
  assign w_a_idx = IDX_W'(A >> IDX_SH);
  assign w_a_tag = TAG_W'(A >> TAG_SH);
  assign w_l_off = OFF_W'((r_addr >> $clog2(WORD_BYTES)) & 32'(LINE_WORDS - 1));
  assign w_l_idx = IDX_W'(r_addr >> IDX_SH);
  assign w_l_tag = TAG_W'(r_addr >> TAG_SH);
  assign w_base  = r_addr & LINE_MASK;

  // Ways are looked up with the live address in IDLE; elsewhere the latched
  // address drives the read port so RESPOND can return the refilled word.
  assign w_lk_idx  = (r_state == IDLE) ? w_a_idx : w_l_idx;
  assign w_lk_off  = (r_state == IDLE) ? w_a_off : w_l_off;
  assign w_cnt_inc = r_cnt + OFF_W'(1);

  logic [WAYS-1:0] w_hit;
  logic [WAYS-1:0] w_valid;
  logic [31:0]     w_word [WAYS];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    icache_way #(
      .NUM_SETS   (NUM_SETS),
      .LINE_WORDS (LINE_WORDS),
      .IDX_W      (IDX_W),
      .OFF_W      (OFF_W),
      .TAG_W      (TAG_W)
    ) u_way (
      .clk        (clk),
      .reset      (reset),
      .i_rd_idx   (w_lk_idx),
      .i_rd_off   (w_lk_off),
      .i_rd_tag   (w_a_tag),
      .o_valid    (w_valid[g]),
      .o_hit      (w_hit[g]),
      .o_word     (w_word[g]),
      .i_wr_en    (w_refill_wr && (r_victim == VW'(g))),
      .i_wr_idx   (w_l_idx),
      .i_wr_off   (r_cnt),
      .i_wr_data  (MData),
      .i_inst_en  (w_install && (r_victim == VW'(g))),
      .i_inst_tag (w_l_tag)
    );
  end

  logic        w_any_hit;
  logic [31:0] w_hit_word;
  logic [31:0] w_vic_word;
  logic [VW-1:0] w_vic;
  logic        w_vic_by_ptr;
  logic        w_found;

  assign w_any_hit = |w_hit;

  always_comb begin
    w_hit_word = '0;
    w_vic_word = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (w_hit[i]) begin
        w_hit_word = w_hit_word | w_word[i];
      end
      if (r_victim == VW'(i)) begin
        w_vic_word = w_word[i];
      end
    end
  end

  // Lowest-numbered invalid way wins; a full set falls back to its pointer.
  always_comb begin
    w_vic        = r_ptr[w_a_idx];
    w_vic_by_ptr = 1'b1;
    w_found      = 1'b0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (!w_valid[i] && !w_found) begin
        w_vic        = VW'(i);
        w_vic_by_ptr = 1'b0;
        w_found      = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_rd_nx      = r_rd;
    w_rdy_nx     = 1'b0;
    w_maddr_nx   = r_maddr;
    w_mread_nx   = r_mread;
    w_addr_nx    = r_addr;
    w_cnt_nx     = r_cnt;
    w_victim_nx  = r_victim;
    w_vic_ptr_nx = r_vic_ptr;
    w_refill_wr  = 1'b0;
    w_install    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (RE) begin
          if (w_any_hit) begin
            w_rd_nx  = w_hit_word;
            w_rdy_nx = 1'b1;
          end else begin
            w_addr_nx    = A;
            w_cnt_nx     = '0;
            w_victim_nx  = w_vic;
            w_vic_ptr_nx = w_vic_by_ptr;
            w_maddr_nx   = A & LINE_MASK;
            w_mread_nx   = 1'b1;
            w_state_nx   = REFILL;
          end
        end
      end
      REFILL: begin
        if (MRdy) begin
          w_refill_wr = 1'b1;
          w_mread_nx  = 1'b0;
          w_state_nx  = (r_cnt == LAST_WORD) ? RESPOND : GAP;
        end
      end
      GAP: begin
        w_cnt_nx   = w_cnt_inc;
        w_maddr_nx = w_base | (32'(w_cnt_inc) * 32'(WORD_BYTES));
        w_mread_nx = 1'b1;
        w_state_nx = REFILL;
      end
      RESPOND: begin
        w_install  = 1'b1;
        w_rd_nx    = w_vic_word;
        w_rdy_nx   = RE;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_rd      <= '0;
      r_rdy     <= 1'b0;
      r_maddr   <= '0;
      r_mread   <= 1'b0;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_victim  <= '0;
      r_vic_ptr <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_rd      <= w_rd_nx;
      r_rdy     <= w_rdy_nx;
      r_maddr   <= w_maddr_nx;
      r_mread   <= w_mread_nx;
      r_addr    <= w_addr_nx;
      r_cnt     <= w_cnt_nx;
      r_victim  <= w_victim_nx;
      r_vic_ptr <= w_vic_ptr_nx;
    end
  end

  // Pointer moves only when it actually picked the victim, so filling
  // invalid ways does not disturb the rotation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        r_ptr[s] <= '0;
      end
    end else if (w_install && r_vic_ptr && (WAYS > 1)) begin
      r_ptr[w_l_idx] <= r_ptr[w_l_idx] + VW'(1);
    end
  end

  assign RD    = r_rd;
  assign RDY   = r_rdy;
  assign MAddr = r_maddr;
  assign MRead = r_mread;

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic        w_hit_ev;
  logic        w_miss_ev;

  assign w_hit_ev  = (r_state == IDLE) && RE && w_any_hit;
  assign w_miss_ev = (r_state == IDLE) && RE && !w_any_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit_ev)  r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss_ev) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: self-checking bench for icache_sa (default parameters)
// with a 9-cycle-latency word-serial memory model and an RD scoreboard.
module tb_icache_sa;

  localparam int unsigned MEM_LAT  = 9;
  localparam int unsigned MISS_LAT = 1 + 4 * MEM_LAT + 3 + 1;
  localparam int unsigned BOUND    = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] A = '0;
  logic        RE = 1'b0;
  logic [31:0] RD;
  logic        RDY;
  logic [31:0] MAddr;
  logic [31:0] MData = '0;
  logic        MRead;
  logic        MRdy = 1'b0;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache_sa #(.WAYS(2), .NUM_SETS(8), .LINE_WORDS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .A          (A),
    .RD         (RD),
    .RE         (RE),
    .RDY        (RDY),
    .MAddr      (MAddr),
    .MData      (MData),
    .MRead      (MRead),
    .MRdy       (MRdy)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    return 32'hC0DE_0000 | (a >> 2);
  endfunction

  // Memory: MRdy rises MEM_LAT cycles after MRead is first seen high and
  // drops once MRead goes low.
  int unsigned lat_cnt = 0;
  always @(negedge clk) begin
    if (MRead && !MRdy) begin
      if (lat_cnt == MEM_LAT - 1) begin
        MRdy  = 1'b1;
        MData = memval(MAddr);
      end else begin
        lat_cnt++;
      end
    end else if (!MRead) begin
      MRdy    = 1'b0;
      lat_cnt = 0;
    end
  end

  // Scoreboard: expected RD words queued at request time.
  logic [31:0] exp_q[$];
  int unsigned rdy_cnt = 0;
  always @(negedge clk) begin
    if (reset && RDY) begin
      rdy_cnt++;
      if (exp_q.size() == 0) check("rdy_unexpected", 32'(RDY), 32'd0);
      else                   check("rd_word", RD, exp_q.pop_front());
    end
  end

  // Memory-port log: address at each MRead rise, low-cycle run before it.
  logic [31:0] maddr_log[$];
  int unsigned gap_log[$];
  bit          seen_high = 1'b0;
  int unsigned low_cnt = 0;
  logic        prev_mread = 1'b0;
  logic [31:0] prev_maddr = '0;
  always @(negedge clk) begin
    if (MRead && !prev_mread) begin
      maddr_log.push_back(MAddr);
      if (seen_high) gap_log.push_back(low_cnt);
    end
    if (MRead && prev_mread) check("maddr_stable", MAddr, prev_maddr);
    if (MRead) begin
      seen_high = 1'b1;
      low_cnt   = 0;
    end else begin
      low_cnt++;
    end
    prev_mread = MRead;
    prev_maddr = MAddr;
  end

  task automatic clear_logs();
    maddr_log.delete();
    gap_log.delete();
    seen_high = 1'b0;
  endtask

  task automatic check_line_fetch(input string name, input logic [31:0] base);
    check({name, "_nwords"}, maddr_log.size(), 32'd4);
    if (maddr_log.size() == 4)
      for (int unsigned i = 0; i < 4; i++) check({name, "_maddr"}, maddr_log[i], base + 32'(4 * i));
    check({name, "_ngaps"}, gap_log.size(), 32'd3);
    for (int unsigned i = 0; i < gap_log.size(); i++) check({name, "_gap"}, gap_log[i], 32'd1);
  endtask

  // Issue one request starting at a negedge; return at the negedge where
  // RDY is seen. RE stays high afterwards only when keep is set.
  task automatic req(input logic [31:0] addr, input bit exp_hit, input bit keep);
    int unsigned n;
    bit got;
    A  = addr;
    RE = 1'b1;
    exp_q.push_back(memval(addr));
    n   = 0;
    got = 1'b0;
    while (!got && n < BOUND) begin
      @(negedge clk);
      n++;
      if (RDY) got = 1'b1;
    end
    if (got) begin
      check("latency", n, exp_hit ? 32'd1 : 32'(MISS_LAT));
      if (exp_hit) check("mread_on_hit", 32'(MRead), 32'd0);
    end else begin
      check("rdy_timeout", 32'(got), 32'd1);
      exp_q.delete();
    end
    if (!keep) begin
      RE = 1'b0;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          exp_hit;
    bit          keep;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    int unsigned snap;

    vecs[0] = '{32'h10,  1'b0, 1'b0};  // cold miss, set 1 -> way 0
    vecs[1] = '{32'h18,  1'b1, 1'b1};  // hit, keep RE for back-to-back
    vecs[2] = '{32'h1C,  1'b1, 1'b0};  // hit on the very next cycle
    vecs[3] = '{32'h90,  1'b0, 1'b0};  // set 1 -> way 1 (invalid way)
    vecs[4] = '{32'h110, 1'b0, 1'b0};  // set full -> pointer evicts way 0
    vecs[5] = '{32'h90,  1'b1, 1'b0};  // still in way 1
    vecs[6] = '{32'h10,  1'b0, 1'b0};  // evicted earlier -> miss

    repeat (3) @(negedge clk);
    check("reset_rdy",   32'(RDY),   32'd0);
    check("reset_mread", 32'(MRead), 32'd0);
    check("reset_rd",    RD,         32'd0);
    check("reset_maddr", MAddr,      32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int unsigned i = 0; i < 7; i++) begin
      clear_logs();
      req(vecs[i].addr, vecs[i].exp_hit, vecs[i].keep);
      if (i == 0) begin
        check_line_fetch("cold", 32'h10);
        check("valid_w0_s1", 32'(dut.g_way[0].u_way.r_valid[1]), 32'd1);
      end
      if (vecs[i].exp_hit) check("hit_no_fetch", maddr_log.size(), 32'd0);
    end
`ifdef ICACHE_PERF_EN
    check("hit_count",  hit_count,  32'd3);
    check("miss_count", miss_count, 32'd4);
`endif

    // Reset during the third word of a refill for 0x20.
    clear_logs();
    A  = 32'h20;
    RE = 1'b1;
    n  = 0;
    while (maddr_log.size() < 3 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("third_word_reached", maddr_log.size(), 32'd3);
    repeat (3) @(negedge clk);
    check("mread_before_reset", 32'(MRead), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("mread_async_reset", 32'(MRead), 32'd0);
    check("rdy_async_reset",   32'(RDY),   32'd0);
    RE = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_logs();
    req(32'h20, 1'b0, 1'b0);
    check_line_fetch("after_reset", 32'h20);

    // RE dropped after the miss is accepted: line installs, no RDY.
    A    = 32'h40;
    RE   = 1'b1;
    snap = rdy_cnt;
    @(negedge clk);
    RE = 1'b0;
    repeat (MISS_LAT + 8) @(negedge clk);
    check("no_rdy_after_drop", rdy_cnt - snap, 32'd0);
    check("mread_idle_after_drop", 32'(MRead), 32'd0);
    clear_logs();
    req(32'h44, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised set-associative instruction cache with multi-word lines. It is the successor to the direct-mapped, one-word-line instruction cache. It sits between the fetch stage (A/RE/RD/RDY) and the word-serial main memory port (MAddr/MRead/MData/MRdy). Misses refill a whole line, one word per memory handshake, and victims are chosen per set by a round-robin pointer.

## Interface

Parameters:
- WAYS, 2: associativity; legal values 1, 2, 4.
- NUM_SETS, 8: sets per way; power of two, ≥2.
- LINE_WORDS, 4: 32-bit words per line; power of two, ≥1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- A  input  32  fetch byte address; A[1:0] ignored.
- RD  output  32  instruction word.
- RE  input  1  read request.
- RDY  output  1  RD valid; one-cycle pulse per completed request.
- MAddr  output  32  main-memory word address (byte address, A[1:0]=0).
- MData  input  32  main-memory read data.
- MRead  output  1  main-memory read request.
- MRdy  input  1  main-memory data valid.
- hit_count  output  32  present only with ICACHE_PERF_EN.
- miss_count  output  32  present only with ICACHE_PERF_EN.

## Operation

- Address split: offset = A[OFF+1:2], where OFF = log2(LINE_WORDS). Index = next log2(NUM_SETS) bits. Tag = the remaining upper bits.
- States: IDLE, REFILL, GAP, RESPOND.
- IDLE:
  - RE=1 and any valid way of the indexed set matches the tag: hit.
    - RD ← word[offset] of the hitting way.
    - RDY ← 1.
    - Stay in IDLE.
  - RE=1 and no way matches: miss.
    - Latch A.
    - Word counter ← 0.
    - Victim ← lowest-numbered invalid way; if none, the set's round-robin pointer.
    - MAddr ← line base.
    - MRead ← 1.
    - Go to REFILL.
- REFILL:
  - Hold MRead=1 and MAddr until MRdy=1 is sampled.
  - On MRdy: write MData into victim word[counter] and set MRead ← 0.
    - If counter = LINE_WORDS−1: go to RESPOND.
    - Otherwise go to GAP.
- GAP:
  - One cycle with MRead=0, which lets memory clear its ready flag.
  - Counter += 1.
  - MAddr ← line base + 4·counter.
  - MRead ← 1.
  - Go to REFILL.
- RESPOND:
  - Set the victim's valid bit and write its tag.
  - Advance the set's round-robin pointer (mod WAYS) only if the victim was chosen by the pointer.
  - RD ← the refilled word at the latched offset.
  - RDY ← 1 only if RE is still 1.
  - Go to IDLE.
- Requester rule: A must be held stable from RE assertion until RDY.
- RE dropped mid-refill: the refill runs to completion and the line is installed. No RDY is issued.
- A changing mid-refill violates the requester rule. The refill still uses the latched address.
- Valid bits are never cleared except by reset. Tag and data arrays are not reset.
- WAYS=1 degenerates to direct-mapped: the pointer is unused.

## Timing

- Reset (reset=0, asynchronous), applied in any state:
  - State → IDLE.
  - RDY=0, MRead=0, RD=0, MAddr=0.
  - All valid bits 0, all round-robin pointers 0.
  - Counters 0.
- Reset mid-refill abandons the line: the victim stays invalid.
- Hit latency: RDY is high the cycle after the edge that samples RE=1. Back-to-back hits give one RDY per cycle.
- RDY is a single-cycle pulse and is 0 in every cycle that does not complete a request.
- Miss latency: 1 + Σ(memory latency per word) + (LINE_WORDS−1) GAP cycles + 1 RESPOND cycle.
- MRead never toggles while waiting for MRdy. It is low for exactly one cycle between words.
- MRdy while MRead=0 is ignored.
- No request is accepted in REFILL, GAP or RESPOND. A hit lookup resumes in IDLE on the cycle after RESPOND.

## Configuration

- ICACHE_PERF_EN defined:
  - hit_count and miss_count ports exist.
  - hit_count increments on each IDLE hit.
  - miss_count increments on each miss entry into REFILL.
  - Both wrap at 2^32, reset to 0, and increment irrespective of RE drop.
- ICACHE_PERF_EN undefined: both ports and their counters are absent. Behaviour is otherwise identical.

## Structure

- Package icache_pkg holds:
  - state enum icache_state_t (IDLE, REFILL, GAP, RESPOND).
  - localparam helper functions for OFF/IDX/TAG widths from NUM_SETS and LINE_WORDS.
  - constant WORD_BYTES=4.
- Sub-module icache_way, instantiated WAYS times in a generate loop:
  - valid/tag/data arrays for one way.
  - combinational hit and read-word outputs.
  - registered word write and tag/valid install.
- Top level holds the FSM, the victim selection, the per-set pointers and the optional counters.

## Test plan

All scenarios use defaults (WAYS=2, NUM_SETS=8, LINE_WORDS=4) and a memory model with 9-cycle latency.
- Cold miss at A=0x10:
  - MAddr sequence 0x10, 0x14, 0x18, 0x1C, each with MRead low for one cycle between words.
  - RDY pulses once with RD=mem[4].
  - Valid bit for way 0, set 1 is set.
- After the line at 0x10, request A=0x18 then 0x1C back-to-back:
  - RDY on consecutive cycles with RD=mem[6], mem[7].
  - MRead stays 0.
- Fill 0x10, then 0x90 (same set, way 1), then 0x110:
  - 0x110 evicts way 0 (pointer).
  - A following 0x90 hits; a following 0x10 misses.
- Assert reset=0 during the third word of a refill for 0x20:
  - MRead and RDY drop immediately.
  - A following 0x20 misses and refills all four words.
- Drop RE during a refill of 0x40:
  - No RDY pulse is issued.
  - A following 0x44 hits in 1 cycle.
- With ICACHE_PERF_EN, run scenarios 1–3:
  - hit_count=3, miss_count=4 (0x10, 0x90, 0x110, 0x10).
